// File: rtl/alu_pkg.sv
// alu_pkg: operation encoding, flag bundle and operand-conditioning helpers for add_pipe.
package alu_pkg;
    typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, ADC = 2'd2, SBB = 2'd3} add_op_e;
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } add_flags_t;
    function automatic logic invert_b(add_op_e op);
        return op[0];
    endfunction
    function automatic logic carry_in(add_op_e op, logic cin);
        return op[1] ? cin ^ op[0] : op[0];
    endfunction
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational CW-bit ripple chunk adder with MSB carry-in and chunk-zero outputs.
module add_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] sum,
    output logic          co,
    output logic          cm,
    output logic          z
);
    logic [CW:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < CW; i++) begin : g_fa
        fulladder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end
    assign co = c[CW];
    assign cm = c[CW-1];
    assign z  = ~|sum;
endmodule

// File: rtl/fulladder.sv
// fulladder: one-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/add_pipe.sv
// add_pipe: STAGES-deep pipelined add/subtract, one CW-bit chunk per stage, valid/ready with backpressure.
module add_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  add_op_e          op_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output add_flags_t       flags_o
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
        $error("add_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic             en;
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic             c_q [STAGES];
    logic             z_q [STAGES];
    logic             ov_q;
    logic             v_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic             c_in [STAGES];
    logic             z_in [STAGES];
    logic [CW-1:0]    sum [STAGES];
    logic             co [STAGES];
    logic             cm [STAGES];
    logic             zc [STAGES];

    assign en          = ~v_q[STAGES-1] | out_ready_i;
    assign in_ready_o  = en & rst_ni;
    assign out_valid_o = v_q[STAGES-1];
    assign result_o    = a_q[STAGES-1];
    assign flags_o     = {c_q[STAGES-1], ov_q, z_q[STAGES-1], a_q[STAGES-1][WIDTH-1]};

    // a/b words rotate right one chunk per stage so the live chunk is always the low one;
    // finished sums enter at the top, leaving the full result in order after the last stage.
    always_comb begin
        v_in[0] = in_valid_i;
        a_in[0] = a_i;
        b_in[0] = invert_b(op_i) ? ~b_i : b_i;
        c_in[0] = carry_in(op_i, cin_i);
        z_in[0] = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            z_in[k] = z_q[k-1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        add_slice #(.CW(CW)) u_slice (
            .a  (a_in[i][CW-1:0]),
            .b  (b_in[i][CW-1:0]),
            .ci (c_in[i]),
            .sum(sum[i]),
            .co (co[i]),
            .cm (cm[i]),
            .z  (zc[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
                z_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                a_q[k] <= (WIDTH'(sum[k]) << (WIDTH - CW)) | (a_in[k] >> CW);
                b_q[k] <= b_in[k] >> CW;
                c_q[k] <= co[k];
                z_q[k] <= z_in[k] & zc[k];
            end
            ov_q <= co[STAGES-1] ^ cm[STAGES-1];
        end
    end
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe at 32/4 (directed), 8/1 and 16/8 (random vs model).
module tb_add_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          issue;
        int          lat;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    logic        iv0 = 0, ir0, cin0 = 0, v0, r0 = 1;
    add_op_e     op0 = ADD;
    logic [31:0] a0 = 0, b0 = 0, res0;
    add_flags_t  fl0;
    logic        iv1 = 0, ir1, cin1 = 0, v1;
    add_op_e     op1 = ADD;
    logic [7:0]  a1 = 0, b1 = 0, res1;
    add_flags_t  fl1;
    logic        iv2 = 0, ir2, cin2 = 0, v2;
    add_op_e     op2 = ADD;
    logic [15:0] a2 = 0, b2 = 0, res2;
    add_flags_t  fl2;

    add_pipe #(.WIDTH(32), .STAGES(4)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv0), .in_ready_o(ir0), .op_i(op0), .cin_i(cin0),
        .a_i(a0), .b_i(b0), .out_valid_o(v0), .out_ready_i(r0), .result_o(res0), .flags_o(fl0));
    add_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv1), .in_ready_o(ir1), .op_i(op1), .cin_i(cin1),
        .a_i(a1), .b_i(b1), .out_valid_o(v1), .out_ready_i(1'b1), .result_o(res1), .flags_o(fl1));
    add_pipe #(.WIDTH(16), .STAGES(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv2), .in_ready_o(ir2), .op_i(op2), .cin_i(cin2),
        .a_i(a2), .b_i(b2), .out_valid_o(v2), .out_ready_i(1'b1), .result_o(res2), .flags_o(fl2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Independent reference: sign-rule overflow rather than carry comparison.
    function automatic logic [35:0] model(add_op_e op, longint unsigned a, longint unsigned b, logic cin, int w);
        longint unsigned m, bb, s;
        logic c0, sa, sb, sr;
        logic [31:0] r;
        m  = (64'd1 << w) - 1;
        bb = (op == SUB || op == SBB) ? (~b & m) : b;
        c0 = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : (op == ADC) ? cin : !cin;
        s  = a + bb + 64'(c0);
        r  = 32'(s & m);
        sa = 1'((a >> (w - 1)) & 1);
        sb = 1'((bb >> (w - 1)) & 1);
        sr = 1'((64'(r) >> (w - 1)) & 1);
        return {r, 1'((s >> w) & 1), (sa == sb) && (sr != sa), r == 0, sr};
    endfunction

    always @(negedge clk) if (rst_n && v0 && r0) begin
        if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL extra0: unexpected result %h", res0);
        end else begin
            e0 = q0.pop_front();
            check("res32", res0, e0.res);
            check("flags32", 32'(fl0), 32'(e0.fl));
            if (e0.lat != 0) check("lat32", cyc - e0.issue, e0.lat);
        end
    end

    always @(negedge clk) if (rst_n && v1) begin
        if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL extra8: unexpected result %h", res1);
        end else begin
            e1 = q1.pop_front();
            check("res8", 32'(res1), e1.res);
            check("flags8", 32'(fl1), 32'(e1.fl));
            check("lat8", cyc - e1.issue, e1.lat);
        end
    end

    always @(negedge clk) if (rst_n && v2) begin
        if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL extra16: unexpected result %h", res2);
        end else begin
            e2 = q2.pop_front();
            check("res16", 32'(res2), e2.res);
            check("flags16", 32'(fl2), 32'(e2.fl));
            check("lat16", cyc - e2.issue, e2.lat);
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send0(add_op_e op, logic [31:0] a, logic [31:0] b, logic cin,
                         logic [31:0] res, logic [3:0] fl, int lat);
        int n = 0;
        op0 = op; a0 = a; b0 = b; cin0 = cin; iv0 = 1;
        @(negedge clk);
        while (!ir0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!ir0) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stuck at %b want 1", ir0);
        end else q0.push_back('{res: res, fl: fl, issue: cyc, lat: lat});
        @(posedge clk); #1;
        iv0 = 0;
    endtask

    task automatic drain(int which);
        int n = 0;
        while (((which == 0 ? q0.size() : q1.size() + q2.size()) != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_left", which == 0 ? q0.size() : q1.size() + q2.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] held;
        logic [35:0] m;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(v0), 0);
        check("rst_result", res0, 0);
        check("rst_flags", 32'(fl0), 0);
        check("rst_ready", 32'(ir0), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("ready_after_rst", 32'(ir0), 1);
        @(posedge clk); #1;

        send0(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 4'b1010, 4); drain(0);
        send0(SUB, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 4'b1100, 4); drain(0);
        send0(ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1, 32'h8000_0000, 4'b0101, 4); drain(0);
        send0(SBB, 32'h0000_0005, 32'h0000_0007, 0, 32'hFFFF_FFFE, 4'b0001, 4); drain(0);
        send0(ADD, 32'h0000_0001, 32'h0000_0001, 1, 32'h0000_0002, 4'b0000, 4); drain(0);
        send0(SUB, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 4'b1010, 4); drain(0);
        send0(ADC, 32'h00FF_FFFF, 32'h0000_0000, 1, 32'h0100_0000, 4'b0000, 4); drain(0);
        send0(SBB, 32'h0000_0000, 32'h0000_0000, 1, 32'hFFFF_FFFF, 4'b0001, 4); drain(0);
        send0(ADD, 32'h1234_5678, 32'h0FED_CBA8, 0, 32'h2222_2220, 4'b0000, 4); drain(0);

        fork
            for (int i = 0; i < 8; i++)
                send0(ADD, 32'(i), 32'(32'h100 * i), 0, 32'(32'h101 * i), (i == 0) ? 4'b0010 : 4'b0000, 0);
            begin
                n = 0;
                @(negedge clk);
                while (!v0 && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check("stream_started", 32'(v0), 1);
                @(posedge clk); #1;
                r0 = 0;
                held = res0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_ready", 32'(ir0), 0);
                    check("stall_valid", 32'(v0), 1);
                    check("stall_result", res0, held);
                end
                @(posedge clk); #1;
                r0 = 1;
            end
        join
        drain(0);

        for (int i = 0; i < 3; i++)
            send0(ADD, 32'h1234_0000 + 32'(i), 32'h0101_0101, 0, 32'h1335_0101 + 32'(i), 4'b0000, 0);
        rst_n = 0;
        q0.delete();
        @(posedge clk);
        @(negedge clk);
        check("inflight_rst_valid", 32'(v0), 0);
        check("inflight_rst_result", res0, 0);
        check("inflight_rst_flags", 32'(fl0), 0);
        check("inflight_rst_ready", 32'(ir0), 0);
        @(posedge clk); #1;
        rst_n = 1;
        send0(SUB, 32'd100, 32'd1, 0, 32'd99, 4'b1000, 4);
        drain(0);
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            op1 = add_op_e'($urandom_range(0, 3)); a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
            op2 = add_op_e'($urandom_range(0, 3)); a2 = 16'($urandom); b2 = 16'($urandom); cin2 = 1'($urandom);
            if (i % 7 == 3) begin a1 = 8'hFF; b1 = 8'h01; op1 = ADD; a2 = 16'h8000; b2 = 16'h0001; op2 = SUB; end
            iv1 = 1; iv2 = 1;
            m = model(op1, 64'(a1), 64'(b1), cin1, 8);
            q1.push_back('{res: m[35:4], fl: m[3:0], issue: cyc, lat: 1});
            m = model(op2, 64'(a2), 64'(b2), cin2, 16);
            q2.push_back('{res: m[35:4], fl: m[3:0], issue: cyc, lat: 8});
            @(posedge clk); #1;
        end
        iv1 = 0; iv2 = 0;
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
